// File: rtl/ramb4_s1_rr_arbiter.sv
// Round-robin arbiter sharing one RAMB4_S1 block RAM between requesters A and B.
// Define RAMB4_ARB_DOREG_EN to register RAM_DO (read latency 3 instead of 2).
module ramb4_s1_rr_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 1,
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] di_a,
  input  logic [DATA_WIDTH-1:0] di_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  dv_a,
  output logic                  dv_b,
  output logic [DATA_WIDTH-1:0] do_a,
  output logic [DATA_WIDTH-1:0] do_b,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE_A,
    ISSUE_B
  } state_t;

  state_t state, state_nx;
  logic   pri, pri_nx;
  logic   elig_a, elig_b;
  logic   pick_a, pick_b;
  logic   rd_v1, rd_id1;

  assign gnt_a  = (state == ISSUE_A);
  assign gnt_b  = (state == ISSUE_B);

  // A port granted this cycle is holding the request it just had accepted.
  assign elig_a = req_a & ~gnt_a;
  assign elig_b = req_b & ~gnt_b;
  assign pick_a = elig_a & (~elig_b | ~pri);
  assign pick_b = elig_b & (~elig_a | pri);

  always_comb begin
    state_nx = IDLE;
    pri_nx   = pri;
    unique case (1'b1)
      pick_a: begin
        state_nx = ISSUE_A;
        pri_nx   = 1'b1;
      end
      pick_b: begin
        state_nx = ISSUE_B;
        pri_nx   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pri      <= RESET_PRIO;
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_di   <= '0;
    end else begin
      state  <= state_nx;
      pri    <= pri_nx;
      ram_en <= pick_a | pick_b;
      ram_we <= pick_a ? we_a : (pick_b & we_b);
      if (pick_a) begin
        ram_addr <= addr_a;
        ram_di   <= di_a;
      end else if (pick_b) begin
        ram_addr <= addr_b;
        ram_di   <= di_b;
      end
    end
  end

  // Read tag follows the access into the RAM; DV is routed by it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1  <= 1'b0;
      rd_id1 <= 1'b0;
    end else begin
      rd_v1  <= ram_en & ~ram_we;
      rd_id1 <= gnt_b;
    end
  end

`ifdef RAMB4_ARB_DOREG_EN
  logic                  rd_v2, rd_id2;
  logic [DATA_WIDTH-1:0] do_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v2  <= 1'b0;
      rd_id2 <= 1'b0;
      do_q   <= '0;
    end else begin
      rd_v2  <= rd_v1;
      rd_id2 <= rd_id1;
      do_q   <= ram_do;
    end
  end

  assign dv_a = rd_v2 & ~rd_id2;
  assign dv_b = rd_v2 & rd_id2;
  assign do_a = dv_a ? do_q : '0;
  assign do_b = dv_b ? do_q : '0;
`else
  assign dv_a = rd_v1 & ~rd_id1;
  assign dv_b = rd_v1 & rd_id1;
  assign do_a = dv_a ? ram_do : '0;
  assign do_b = dv_b ? ram_do : '0;
`endif

endmodule
